// File: rtl/dsp_muladd_acc_pipe.sv
// Unsigned pipelined y = a*b + c (load) or y = a*b + y (accumulate), with valid tracking and overflow flag.
// Latency 2+MREG cycles at one beat per cycle; en=0 freezes every stage (hold, no drop).
// Optional saturation build: define DSP_MULADD_SAT_EN to clamp y to all-ones on overflow instead of wrapping.
module dsp_muladd_acc_pipe #(
  parameter int AW   = 8,
  parameter int BW   = 8,
  parameter int CW   = 16,
  parameter int YW   = 16,
  parameter int MREG = 1
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          en,
  input  logic          in_valid,
  input  logic [AW-1:0] a,
  input  logic [BW-1:0] b,
  input  logic [CW-1:0] c,
  input  logic          acc,
  output logic          out_valid,
  output logic [YW-1:0] y,
  output logic          ovf
);

  localparam int PW = AW + BW;
  // Sum width is wide enough that no carry is lost; every bit at or above YW means overflow.
  localparam int XW = ((PW > YW) ? PW : YW) + 1;

  logic [AW-1:0] a_q;
  logic [BW-1:0] b_q;
  logic [CW-1:0] c_q;
  logic          acc_q;
  logic          v1_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      a_q   <= '0;
      b_q   <= '0;
      c_q   <= '0;
      acc_q <= 1'b0;
      v1_q  <= 1'b0;
    end else if (en) begin
      a_q   <= a;
      b_q   <= b;
      c_q   <= c;
      acc_q <= acc;
      v1_q  <= in_valid;
    end
  end

  logic [PW-1:0] prod_s1;
  assign prod_s1 = PW'(a_q) * PW'(b_q);

  logic [PW-1:0] pm;
  logic [CW-1:0] pc;
  logic          pacc;
  logic          pv;

  if (MREG == 1) begin : g_mreg
    logic [PW-1:0] m_q;
    logic [CW-1:0] cm_q;
    logic          accm_q;
    logic          vm_q;

    always_ff @(posedge clock) begin
      if (reset) begin
        m_q    <= '0;
        cm_q   <= '0;
        accm_q <= 1'b0;
        vm_q   <= 1'b0;
      end else if (en) begin
        m_q    <= prod_s1;
        cm_q   <= c_q;
        accm_q <= acc_q;
        vm_q   <= v1_q;
      end
    end

    assign pm   = m_q;
    assign pc   = cm_q;
    assign pacc = accm_q;
    assign pv   = vm_q;
  end else begin : g_nomreg
    assign pm   = prod_s1;
    assign pc   = c_q;
    assign pacc = acc_q;
    assign pv   = v1_q;
  end

  logic [XW-1:0] addend_x;
  logic [XW-1:0] sum_x;
  logic          sum_ovf;
  logic [YW-1:0] y_d, y_q;
  logic          ovf_d, ovf_q;
  logic          ov_d, ov_q;

  // Accumulate reads y_q as it stands while the beat sits in stage P, so back-to-back beats chain.
  always_comb begin
    addend_x = pacc ? {{(XW-YW){1'b0}}, y_q} : {{(XW-CW){1'b0}}, pc};
    sum_x    = {{(XW-PW){1'b0}}, pm} + addend_x;
    sum_ovf  = |sum_x[XW-1:YW];
    y_d      = y_q;
    ovf_d    = 1'b0;
    ov_d     = pv;
    if (pv) begin
      ovf_d = sum_ovf;
`ifdef DSP_MULADD_SAT_EN
      y_d   = sum_ovf ? {YW{1'b1}} : sum_x[YW-1:0];
`else
      y_d   = sum_x[YW-1:0];
`endif
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      y_q   <= '0;
      ovf_q <= 1'b0;
      ov_q  <= 1'b0;
    end else if (en) begin
      y_q   <= y_d;
      ovf_q <= ovf_d;
      ov_q  <= ov_d;
    end
  end

  assign y         = y_q;
  assign ovf       = ovf_q;
  assign out_valid = ov_q;

endmodule

// File: tb/tb_dsp_muladd_acc_pipe.sv
// Directed bench for dsp_muladd_acc_pipe: table-driven stream on MREG=1 plus stall, reset and MREG=0 sequences.
module tb_dsp_muladd_acc_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        in_valid;
  logic [7:0]  a, b;
  logic [15:0] c;
  logic        acc;
  logic        out_valid, ovf;
  logic [15:0] y;
  logic        out_valid0, ovf0;
  logic [15:0] y0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dsp_muladd_acc_pipe #(.AW(8), .BW(8), .CW(16), .YW(16), .MREG(1)) dut (
    .clock(clk), .reset(rst), .en(en), .in_valid(in_valid), .a(a), .b(b), .c(c), .acc(acc),
    .out_valid(out_valid), .y(y), .ovf(ovf)
  );

  dsp_muladd_acc_pipe #(.AW(8), .BW(8), .CW(16), .YW(16), .MREG(0)) dut0 (
    .clock(clk), .reset(rst), .en(en), .in_valid(in_valid), .a(a), .b(b), .c(c), .acc(acc),
    .out_valid(out_valid0), .y(y0), .ovf(ovf0)
  );

  typedef struct {
    logic        vld;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] c;
    logic        acc;
    logic [15:0] ey;
    logic        eovf;
  } vec_t;

  localparam int N = 12;
  vec_t vt[N];

`ifdef DSP_MULADD_SAT_EN
  localparam logic [15:0] Y_BIG  = 16'hFFFF;
  localparam logic [15:0] Y_BIG1 = 16'hFFFF;
  localparam logic        O_BIG1 = 1'b1;
  localparam logic [15:0] Y_WRAP = 16'hFFFF;
`else
  localparam logic [15:0] Y_BIG  = 16'hFE00;
  localparam logic [15:0] Y_BIG1 = 16'hFE01;
  localparam logic        O_BIG1 = 1'b0;
  localparam logic [15:0] Y_WRAP = 16'h0001;
`endif

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [7:0] ia, input logic [7:0] ib,
                       input logic [15:0] ic, input logic iacc);
    in_valid = v;
    a        = ia;
    b        = ib;
    c        = ic;
    acc      = iacc;
  endtask

  task automatic chk_out(input string name, input logic ev, input logic [15:0] ey, input logic eo);
    chk({name, ".out_valid"}, {31'd0, out_valid}, {31'd0, ev});
    chk({name, ".y"}, {16'd0, y}, {16'd0, ey});
    if (ev) chk({name, ".ovf"}, {31'd0, ovf}, {31'd0, eo});
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(1'b0, 8'd0, 8'd0, 16'd0, 1'b0);
    tick();
    rst = 1'b0;
  endtask

  initial begin
    vt[0]  = '{1'b1, 8'd3,   8'd4,   16'd5,     1'b0, 16'd17,   1'b0};
    vt[1]  = '{1'b1, 8'd2,   8'd3,   16'd1,     1'b0, 16'd7,    1'b0};
    vt[2]  = '{1'b1, 8'd4,   8'd5,   16'd0,     1'b1, 16'd27,   1'b0};
    vt[3]  = '{1'b1, 8'd10,  8'd10,  16'd0,     1'b1, 16'd127,  1'b0};
    vt[4]  = '{1'b0, 8'd9,   8'd9,   16'd0,     1'b1, 16'd127,  1'b0};
    vt[5]  = '{1'b1, 8'd255, 8'd255, 16'hFFFF,  1'b0, Y_BIG,    1'b1};
    vt[6]  = '{1'b1, 8'd1,   8'd1,   16'd0,     1'b1, Y_BIG1,   O_BIG1};
    vt[7]  = '{1'b1, 8'd0,   8'd0,   16'd0,     1'b0, 16'd0,    1'b0};
    vt[8]  = '{1'b1, 8'd0,   8'd200, 16'd0,     1'b1, 16'd0,    1'b0};
    vt[9]  = '{1'b1, 8'd16,  8'd16,  16'h0100,  1'b0, 16'h0200, 1'b0};
    vt[10] = '{1'b1, 8'd255, 8'd255, 16'd0,     1'b1, Y_WRAP,   1'b1};
    vt[11] = '{1'b1, 8'd0,   8'd0,   16'hFFFF,  1'b0, 16'hFFFF, 1'b0};

    en = 1'b1;
    do_reset();
    chk_out("reset", 1'b0, 16'd0, 1'b0);
    chk("reset.ovf", {31'd0, ovf}, 32'd0);

    // Test 1: single beat, 3-cycle latency
    drive(1'b1, 8'd3, 8'd4, 16'd5, 1'b0);
    tick();
    drive(1'b0, 8'd0, 8'd0, 16'd0, 1'b0);
    tick();
    chk("t1.lat2", {31'd0, out_valid}, 32'd0);
    tick();
    chk_out("t1", 1'b1, 16'd17, 1'b0);
    tick();
    chk_out("t1.after", 1'b0, 16'd17, 1'b0);

    // Back-to-back table stream (covers chained accumulate, bubble, overflow and wrap/saturate)
    do_reset();
    for (int i = 0; i < N + 2; i++) begin
      if (i < N) drive(vt[i].vld, vt[i].a, vt[i].b, vt[i].c, vt[i].acc);
      else       drive(1'b0, 8'd0, 8'd0, 16'd0, 1'b0);
      tick();
      if (i >= 2) chk_out($sformatf("vec%0d", i - 2), vt[i-2].vld, vt[i-2].ey, vt[i-2].eovf);
      else        chk($sformatf("vec_fill%0d", i), {31'd0, out_valid}, 32'd0);
    end

    // Test 3: en=0 for 2 cycles after 2nd beat, and a further stall while y is valid
    do_reset();
    drive(1'b1, 8'd2, 8'd3, 16'd1, 1'b0);
    tick();
    drive(1'b1, 8'd4, 8'd5, 16'd0, 1'b1);
    tick();
    en = 1'b0;
    drive(1'b1, 8'd9, 8'd9, 16'd9, 1'b0);
    tick();
    chk_out("t3.stall1", 1'b0, 16'd0, 1'b0);
    tick();
    chk_out("t3.stall2", 1'b0, 16'd0, 1'b0);
    en = 1'b1;
    drive(1'b1, 8'd10, 8'd10, 16'd0, 1'b1);
    tick();
    chk_out("t3.b1", 1'b1, 16'd7, 1'b0);
    en = 1'b0;
    drive(1'b1, 8'd9, 8'd9, 16'd9, 1'b0);
    tick();
    chk_out("t3.hold", 1'b1, 16'd7, 1'b0);
    en = 1'b1;
    drive(1'b0, 8'd0, 8'd0, 16'd0, 1'b0);
    tick();
    chk_out("t3.b2", 1'b1, 16'd27, 1'b0);
    tick();
    chk_out("t3.b3", 1'b1, 16'd127, 1'b0);
    tick();
    chk_out("t3.end", 1'b0, 16'd127, 1'b0);

    // Test 5: reset with two beats in flight
    drive(1'b1, 8'd1, 8'd1, 16'd1, 1'b0);
    tick();
    drive(1'b1, 8'd2, 8'd2, 16'd0, 1'b0);
    tick();
    rst = 1'b1;
    drive(1'b0, 8'd0, 8'd0, 16'd0, 1'b0);
    tick();
    rst = 1'b0;
    chk_out("t5.rst", 1'b0, 16'd0, 1'b0);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk_out($sformatf("t5.drain%0d", k), 1'b0, 16'd0, 1'b0);
    end

    // Test 6: MREG=0 instance, 2-cycle latency
    do_reset();
    drive(1'b1, 8'd7, 8'd6, 16'd0, 1'b0);
    tick();
    drive(1'b0, 8'd0, 8'd0, 16'd0, 1'b0);
    chk("t6.m0.lat1", {31'd0, out_valid0}, 32'd0);
    tick();
    chk("t6.m0.vld", {31'd0, out_valid0}, 32'd1);
    chk("t6.m0.y", {16'd0, y0}, 32'd42);
    chk("t6.m0.ovf", {31'd0, ovf0}, 32'd0);
    chk("t6.m1.lat2", {31'd0, out_valid}, 32'd0);
    tick();
    chk("t6.m0.after", {31'd0, out_valid0}, 32'd0);
    chk_out("t6.m1", 1'b1, 16'd42, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
